ssd_time_mux: RTL

//  Time-multiplexes two 4-bit digit values onto one shared seven-segment decoder input.

---
 rtl/ssd_pkg.sv | 16 +
 rtl/ssd_dwell_counter.sv | 27 ++
 rtl/ssd_time_mux.sv | 117 +++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types for the seven-segment time multiplexer.
// States and anode polarity used by ssd_time_mux.
package ssd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIG1,
    BLANK1,
    DIG2,
    BLANK2
  } mux_state_t;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/ssd_dwell_counter.sv
// Dwell counter: sync clear, count-up, saturating at a runtime limit.
// term is high while the count equals the limit.
module ssd_dwell_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic          term
);

  logic [CW-1:0] cnt;

  assign term = (cnt == limit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_time_mux.sv
// Two-digit seven-segment time multiplexer with per-frame snapshot.
// Define SSD_MUX_BLANK_EN to insert dead-time blanking between digits.
module ssd_time_mux
  import ssd_pkg::*;
#(
  parameter int DIV_MAX   = 24000,
  parameter int BLANK_CYC = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s_1,
  input  logic [3:0] s_2,
  output logic [3:0] sel,
  output logic       an_1,
  output logic       an_2,
  output logic       frame_tick
);

  localparam int MX = (DIV_MAX > BLANK_CYC) ? DIV_MAX : BLANK_CYC;
  localparam int CW = $clog2(MX);

  mux_state_t    state_q;
  mux_state_t    state_d;
  logic [3:0]    d1_q;
  logic [3:0]    d2_q;
  logic [3:0]    d1_d;
  logic [3:0]    d2_d;
  logic [3:0]    sel_d;
  logic          an_1_d;
  logic          an_2_d;
  logic          start;
  logic          term;
  logic [CW-1:0] limit;

  ssd_dwell_counter #(
    .CW(CW)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (state_d != state_q),
    .limit(limit),
    .term (term)
  );

`ifdef SSD_MUX_BLANK_EN
  assign limit = (state_q == BLANK1 || state_q == BLANK2)
               ? CW'(BLANK_CYC - 1) : CW'(DIV_MAX - 1);
`else
  assign limit = CW'(DIV_MAX - 1);
`endif

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = DIG1;
`ifdef SSD_MUX_BLANK_EN
        DIG1:    if (term) state_d = BLANK1;
        BLANK1:  if (term) state_d = DIG2;
        DIG2:    if (term) state_d = BLANK2;
        BLANK2:  if (term) state_d = DIG1;
`else
        DIG1:    if (term) state_d = DIG2;
        DIG2:    if (term) state_d = DIG1;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they register in step.
  always_comb begin
    start  = (state_d == DIG1) && (state_q != DIG1);
    d1_d   = start ? s_1 : d1_q;
    d2_d   = start ? s_2 : d2_q;
    sel_d  = 4'h0;
    an_1_d = AN_OFF;
    an_2_d = AN_OFF;
    unique case (state_d)
      DIG1: begin
        sel_d  = d1_d;
        an_1_d = AN_ON;
      end
      BLANK1: sel_d = d1_d;
      DIG2: begin
        sel_d  = d2_d;
        an_2_d = AN_ON;
      end
      BLANK2: sel_d = d2_d;
      default: sel_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      d1_q       <= 4'h0;
      d2_q       <= 4'h0;
      sel        <= 4'h0;
      an_1       <= AN_OFF;
      an_2       <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      sel        <= sel_d;
      an_1       <= an_1_d;
      an_2       <= an_2_d;
      frame_tick <= start;
    end
  end

endmodule
